// File: rtl/local_mean_pkg.sv
// Shared types and constants for the local_mean 3x3 box-filter stage.
// Latency: n/a (package only).
// Backpressure: n/a; optional border mode selected by LOCAL_MEAN_BORDER_REPLICATE_EN.
package local_mean_pkg;

  // Sequencer phases of one pixel: 9 fetch cycles, 1 drain, 1 write.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pipeline phase value that enables this stage.
  localparam logic [2:0] GS_LOCAL_MEAN = 3'd1;

  // ceil(2^16/9); (S*RECIP9)>>16 equals floor(S/9) for every S in 0..2295.
  localparam logic [15:0] RECIP9 = 16'd7282;

  localparam logic [3:0] WIN_LAST = 4'd8;

  // Two-bit signed window offsets.
  localparam logic [1:0] OFS_NEG  = 2'b11;
  localparam logic [1:0] OFS_ZERO = 2'b00;
  localparam logic [1:0] OFS_POS  = 2'b01;

  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
  } win_ofs_t;

  // Window offset table: k walks the 3x3 window row-major from (-1,-1) to (+1,+1).
  function automatic win_ofs_t win_offset(input logic [3:0] k);
    win_ofs_t o;
    o = '{dr: OFS_ZERO, dc: OFS_ZERO};
    case (k)
      4'd0: o = '{dr: OFS_NEG,  dc: OFS_NEG};
      4'd1: o = '{dr: OFS_NEG,  dc: OFS_ZERO};
      4'd2: o = '{dr: OFS_NEG,  dc: OFS_POS};
      4'd3: o = '{dr: OFS_ZERO, dc: OFS_NEG};
      4'd4: o = '{dr: OFS_ZERO, dc: OFS_ZERO};
      4'd5: o = '{dr: OFS_ZERO, dc: OFS_POS};
      4'd6: o = '{dr: OFS_POS,  dc: OFS_NEG};
      4'd7: o = '{dr: OFS_POS,  dc: OFS_ZERO};
      4'd8: o = '{dr: OFS_POS,  dc: OFS_POS};
      default: o = '{dr: OFS_ZERO, dc: OFS_ZERO};
    endcase
    return o;
  endfunction

  // Divide a 9-sample sum by 9 using the reciprocal multiply.
  function automatic logic [7:0] div9(input logic [11:0] sum);
    logic [27:0] prod;
    prod = {16'd0, sum} * {12'd0, RECIP9};
    return prod[23:16];
  endfunction

endpackage

// File: rtl/local_mean_window_addr_gen.sv
// Maps a centre pixel and window index k to a clamped image address plus out-of-range flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module window_addr_gen
  import local_mean_pkg::*;
#(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic [WIDTH_BITS-1:0]  centre_col,
  input  logic [HEIGHT_BITS-1:0] centre_row,
  input  logic [3:0]             k,
  output logic [WIDTH_BITS-1:0]  col,
  output logic [HEIGHT_BITS-1:0] row,
  output logic                   out_of_range
);

  win_ofs_t               ofs;
  logic [WIDTH_BITS:0]    col_ext;
  logic [HEIGHT_BITS:0]   row_ext;
  logic                   col_lo, col_hi, row_lo, row_hi;

  // Add offsets one bit wider than the port so -1 and max+1 show up in the extra MSB;
  // the offset sign then tells underflow from overflow.
  always_comb begin
    ofs     = win_offset(k);
    col_ext = {1'b0, centre_col} + {{(WIDTH_BITS-1){ofs.dc[1]}}, ofs.dc};
    row_ext = {1'b0, centre_row} + {{(HEIGHT_BITS-1){ofs.dr[1]}}, ofs.dr};
    col_lo  = col_ext[WIDTH_BITS]  &  ofs.dc[1];
    col_hi  = col_ext[WIDTH_BITS]  & ~ofs.dc[1];
    row_lo  = row_ext[HEIGHT_BITS] &  ofs.dr[1];
    row_hi  = row_ext[HEIGHT_BITS] & ~ofs.dr[1];
    col     = col_lo ? '0 : (col_hi ? '1 : col_ext[WIDTH_BITS-1:0]);
    row     = row_lo ? '0 : (row_hi ? '1 : row_ext[HEIGHT_BITS-1:0]);
    out_of_range = col_lo | col_hi | row_lo | row_hi;
  end

endmodule

// File: rtl/local_mean.sv
// 3x3 local-mean (floor(S/9)) over the whole image in raster order, writing the threshold map.
// Latency: 11 cycles per pixel (9 fetch, 1 drain, 1 write); frame = 11*2^(W+H) cycles.
// Backpressure: none; memories always accept. LOCAL_MEAN_BORDER_REPLICATE_EN selects edge replicate, else zero padding.
module local_mean
  import local_mean_pkg::*;
#(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             global_state,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oThresholdCol,
  output logic [HEIGHT_BITS-1:0] oThresholdRow,
  output logic [7:0]             oThresholdData,
  output logic                   oThresholdWe,
  output logic                   finished
);

  localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;

  state_t                state;
  logic [POS_BITS-1:0]   pos;
  logic [3:0]            k;
  logic [11:0]           acc;
  logic                  oob_now;
  logic                  oob_q;
  logic [7:0]            sample;
  logic [11:0]           sum_next;
  logic [WIDTH_BITS-1:0]  pos_col;
  logic [HEIGHT_BITS-1:0] pos_row;

  assign pos_col = pos[WIDTH_BITS-1:0];
  assign pos_row = pos[POS_BITS-1:WIDTH_BITS];

  window_addr_gen #(
    .WIDTH_BITS  (WIDTH_BITS),
    .HEIGHT_BITS (HEIGHT_BITS)
  ) u_addr (
    .centre_col   (pos_col),
    .centre_row   (pos_row),
    .k            (k),
    .col          (oImageCol),
    .row          (oImageRow),
    .out_of_range (oob_now)
  );

  // Out-of-range flag delayed to line up with the synchronous-read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) oob_q <= 1'b0;
    else       oob_q <= oob_now;
  end

  // Sample entering the accumulator: edge replicate uses the clamped read as-is,
  // zero padding masks reads that fell outside the image.
  always_comb begin
`ifdef LOCAL_MEAN_BORDER_REPLICATE_EN
    sample = iImageData;
`else
    sample = oob_q ? 8'd0 : iImageData;
`endif
    sum_next = acc + {4'd0, sample};
  end

  // Pixel sequencer: fetch 9 taps, drain the last read, write the mean, advance or finish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      pos            <= '0;
      k              <= '0;
      acc            <= '0;
      finished       <= 1'b0;
      oThresholdWe   <= 1'b0;
      oThresholdData <= '0;
      oThresholdCol  <= '0;
      oThresholdRow  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          k <= '0;
          if (global_state == GS_LOCAL_MEAN && !finished) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (k == 4'd0) acc <= '0;
          else           acc <= sum_next;
          if (k == WIN_LAST) begin
            k     <= '0;
            state <= ST_DRAIN;
          end else begin
            k <= k + 4'd1;
          end
        end
        ST_DRAIN: begin
          acc            <= sum_next;
          oThresholdData <= div9(sum_next);
          oThresholdCol  <= pos_col;
          oThresholdRow  <= pos_row;
          oThresholdWe   <= 1'b1;
          state          <= ST_WRITE;
        end
        ST_WRITE: begin
          oThresholdWe <= 1'b0;
          if (&pos) begin
            finished <= 1'b1;
            state    <= ST_DONE;
          end else begin
            pos   <= pos + {{(POS_BITS-1){1'b0}}, 1'b1};
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          oThresholdWe <= 1'b0;
          finished     <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_mean.sv
// Scoreboarded random bench for local_mean on a 4x4 image.
// Latency: checks the 176-cycle frame time from leaving IDLE to finished.
// Backpressure: n/a; border mode follows LOCAL_MEAN_BORDER_REPLICATE_EN.
module tb_local_mean;

  localparam int WB    = 2;
  localparam int HB    = 2;
  localparam int SIDE  = 4;
  localparam int NPIX  = 16;
  localparam int FRAME = 176;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    global_state = 3'd0;
  logic [WB-1:0] oImageCol;
  logic [HB-1:0] oImageRow;
  logic [7:0]    iImageData = 8'd0;
  logic [WB-1:0] oThresholdCol;
  logic [HB-1:0] oThresholdRow;
  logic [7:0]    oThresholdData;
  logic          oThresholdWe;
  logic          finished;

  logic [7:0] img [0:NPIX-1];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int row;
    int col;
    int data;
  } exp_t;
  exp_t exp_q[$];

  local_mean #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
    .clock          (clock),
    .reset          (reset),
    .global_state   (global_state),
    .oImageCol      (oImageCol),
    .oImageRow      (oImageRow),
    .iImageData     (iImageData),
    .oThresholdCol  (oThresholdCol),
    .oThresholdRow  (oThresholdRow),
    .oThresholdData (oThresholdData),
    .oThresholdWe   (oThresholdWe),
    .finished       (finished)
  );

  always #5 clock = ~clock;

  // Image memory: synchronous read, data one cycle after the address.
  always @(posedge clock) iImageData <= img[{oImageRow, oImageCol}];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: mean of the 3x3 neighbourhood using the chosen border rule.
  function automatic int ref_mean(input int r, input int c);
    int sum = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
`ifdef LOCAL_MEAN_BORDER_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > SIDE-1) rr = SIDE-1;
        if (cc < 0) cc = 0;
        if (cc > SIDE-1) cc = SIDE-1;
        sum += int'(img[rr*SIDE + cc]);
`else
        if (rr >= 0 && rr < SIDE && cc >= 0 && cc < SIDE) sum += int'(img[rr*SIDE + cc]);
`endif
      end
    end
    return sum / 9;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < SIDE; r++) begin
      for (int c = 0; c < SIDE; c++) begin
        e.row  = r;
        e.col  = c;
        e.data = ref_mean(r, c);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: every write strobe must match the next expected pixel.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && oThresholdWe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: row %0d col %0d data %0d, expected no write",
                 oThresholdRow, oThresholdCol, oThresholdData);
      end else begin
        e = exp_q.pop_front();
        check("write_row",  32'(oThresholdRow),  32'(e.row));
        check("write_col",  32'(oThresholdCol),  32'(e.col));
        check("write_data", 32'(oThresholdData), 32'(e.data));
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    global_state = 3'd0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_frame(input bit drop_gs);
    int cycles;
    push_frame();
    @(negedge clock);
    #1 global_state = 3'd1;
    @(posedge clock);
    #1;
    if (drop_gs) global_state = 3'($urandom_range(2, 7));
    cycles = 0;
    while (!finished && cycles < 2000) begin
      @(posedge clock);
      #1 cycles++;
    end
    check("frame_cycles", 32'(cycles), 32'(FRAME));
    check("finished_set", 32'(finished), 32'd1);
    check("writes_left",  32'(exp_q.size()), 32'd0);
    exp_q.delete();
    global_state = 3'd0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    int n;
    bit found;
    fill_random();

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("rst_we",    32'(oThresholdWe),   32'd0);
    check("rst_fin",   32'(finished),       32'd0);
    check("rst_data",  32'(oThresholdData), 32'd0);
    check("rst_tcol",  32'(oThresholdCol),  32'd0);
    check("rst_trow",  32'(oThresholdRow),  32'd0);
    check("rst_icol",  32'(oImageCol),      32'd0);
    check("rst_irow",  32'(oImageRow),      32'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    // Non-running phases must not start the block
    global_state = 3'd0;
    repeat (50) @(negedge clock);
    check("idle_gs0_fin", 32'(finished), 32'd0);
    global_state = 3'd2;
    repeat (50) @(negedge clock);
    check("idle_gs2_fin", 32'(finished), 32'd0);
    check("idle_gs2_we",  32'(oThresholdWe), 32'd0);

    // Uniform 100 image
    for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
    run_frame(1'b0);

    // DONE is sticky regardless of phase
    for (int g = 0; g < 8; g++) begin
      global_state = 3'(g);
      repeat (5) @(negedge clock);
      #1 check("done_sticky", 32'(finished), 32'd1);
    end

    // All-255: maximum sum
    do_reset();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
    run_frame(1'b0);

    // Sum of 9k-1 at an interior pixel: exact floor
    do_reset();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
    img[5] = 8'd254;
    run_frame(1'b0);

    // Reset during the write of pixel 5 aborts the frame
    do_reset();
    fill_random();
    push_frame();
    @(negedge clock);
    #1 global_state = 3'd1;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge clock);
      n++;
      if (oThresholdWe && oThresholdRow == 2'd1 && oThresholdCol == 2'd1) found = 1'b1;
    end
    check("abort_reached", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_we",  32'(oThresholdWe), 32'd0);
    check("abort_fin", 32'(finished),     32'd0);
    exp_q.delete();
    global_state = 3'd0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    run_frame(1'b0);

    // Random images, some with the phase dropped mid-frame
    for (int t = 0; t < 4; t++) begin
      do_reset();
      fill_random();
      run_frame(t[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
